decode: RTL and testbench
=========================

// Module: decode
// PURPOSE
//   MIPS instruction decoder for the 5-stage pipeline. Control outputs are purely combinational
//   from instr and are instantiated wherever a stage needs them (D, E, M, W); the DM stage uses
//   MemWrite and lwso. One sticky register flags any unsupported encoding seen since reset.
// PARAMETERS
//   LWSO_OPC  6'b111111  opcode of custom lwso (load word, signed-overflow-checked add to rt)
// PORTS
//   clk        in   1   system clock; only the illegal flag is clocked
//   reset      in   1   synchronous, active-high; clears illegal
//   instr      in   32  instruction word; opcode [31:26], funct [5:0]
//   RegWrite   out  1   GPR write enable
//   RegDst     out  2   0=rt, 1=rd, 2=$31
//   ALUSrc     out  1   0=rt value, 1=extended imm
//   ALUOp      out  3   0=add, 1=sub, 2=or, 3=lui (imm<<16), others unused
//   ExtOp      out  1   0=zero-extend imm16, 1=sign-extend
//   MemWrite   out  1   data memory store enable
//   MemtoReg   out  2   0=ALU, 1=DM read data, 2=PC+8
//   Branch     out  1   beq
//   Jump       out  1   j/jal (26-bit target)
//   JumpReg    out  1   jr
//   lwso       out  1   instr is lwso
//   illegal    out  1   sticky: unsupported encoding decoded since reset
// BEHAVIOUR
//   - Supported: R-type (opc 0) addu f=100001, subu f=100011, jr f=001000, sll f=000000
//     (nop/sll, treated as no-op: all controls 0); ori 001101, lw 100011, sw 101011,
//     beq 000100, lui 001111, j 000010, jal 000011, lwso LWSO_OPC.
//   - Default (every output) = 0; each instr drives only listed non-zero fields:
//     addu: RegWrite, RegDst=1, ALUOp=0 | subu: RegWrite, RegDst=1, ALUOp=1
//     ori: RegWrite, ALUSrc, ALUOp=2, ExtOp=0 | lui: RegWrite, ALUSrc, ALUOp=3
//     lw: RegWrite, ALUSrc, ExtOp=1, MemtoReg=1 | sw: ALUSrc, ExtOp=1, MemWrite
//     beq: Branch, ALUOp=1 | j: Jump | jal: Jump, RegWrite, RegDst=2, MemtoReg=2
//     jr: JumpReg | lwso: as lw plus lwso=1; MemWrite=0 (DM adds rt and suppresses write on overflow).
//   - All decode is combinational, zero latency; no state other than illegal.
//   - Unsupported opcode, or opcode 0 with an unlisted funct: all control outputs 0 (acts as nop).
//   - illegal: at posedge clk, reset=1 -> 0 (reset wins over a simultaneous illegal instr);
//     else if current instr unsupported -> 1; otherwise holds. Reset value 0.
//   - Only opcode/funct are examined; rs/rt/rd/shamt/imm never affect controls
//     (so sll with nonzero shamt is still a no-op).
// TESTING
//   - 0xAD090004 (sw $9,4($8)) -> MemWrite=1, ALUSrc=1, ExtOp=1, RegWrite=0, lwso=0
//   - 0x8D090004 (lw) -> RegWrite=1, RegDst=0, MemtoReg=1, MemWrite=0;
//     0xFD090004 (lwso) -> same plus lwso=1
//   - 0x00221821 (addu $3,$1,$2) -> RegWrite=1, RegDst=1, ALUOp=0; 0x00000000 -> all outputs 0
//   - 0x0C000010 (jal) -> Jump=1, RegWrite=1, RegDst=2, MemtoReg=2; 0x03E00008 (jr $31) -> JumpReg=1 only
//   - reset 1 cycle, then 0xF8000000 for one edge -> illegal=1 from that edge and stays 1 with valid
//     instrs; controls all 0 while it is applied
//   - 0xF8000000 with reset=1 at same edge -> illegal=0 after edge

Source files
------------

// File: rtl/decode.sv
// MIPS instruction decoder: combinational control generation from opcode/funct,
// plus a sticky flag that records any unsupported encoding seen since reset.
module decode #(
  parameter logic [5:0] LWSO_OPC = 6'b111111
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  output logic        RegWrite,
  output logic [1:0]  RegDst,
  output logic        ALUSrc,
  output logic [2:0]  ALUOp,
  output logic        ExtOp,
  output logic        MemWrite,
  output logic [1:0]  MemtoReg,
  output logic        Branch,
  output logic        Jump,
  output logic        JumpReg,
  output logic        lwso,
  output logic        illegal
);

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_ORI   = 6'b001101;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_LUI   = 6'b001111;
  localparam logic [5:0] OPC_J     = 6'b000010;
  localparam logic [5:0] OPC_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_SLL  = 6'b000000;

  logic [5:0] opcode_s;
  logic [5:0] funct_s;
  logic       reg_write_s;
  logic [1:0] reg_dst_s;
  logic       alu_src_s;
  logic [2:0] alu_op_s;
  logic       ext_op_s;
  logic       mem_write_s;
  logic [1:0] mem_to_reg_s;
  logic       branch_s;
  logic       jump_s;
  logic       jump_reg_s;
  logic       lwso_s;
  logic       supported_s;
  logic       illegal_r;

  assign opcode_s = instr[31:26];
  assign funct_s  = instr[5:0];

  // Control decode: everything defaults to 0, so unsupported encodings act as nop.
  always_comb begin
    reg_write_s  = 1'b0;
    reg_dst_s    = 2'd0;
    alu_src_s    = 1'b0;
    alu_op_s     = 3'd0;
    ext_op_s     = 1'b0;
    mem_write_s  = 1'b0;
    mem_to_reg_s = 2'd0;
    branch_s     = 1'b0;
    jump_s       = 1'b0;
    jump_reg_s   = 1'b0;
    lwso_s       = 1'b0;
    supported_s  = 1'b1;
    if (opcode_s == LWSO_OPC) begin
      // lwso loads like lw; the memory stage does the checked add to rt.
      reg_write_s  = 1'b1;
      alu_src_s    = 1'b1;
      ext_op_s     = 1'b1;
      mem_to_reg_s = 2'd1;
      lwso_s       = 1'b1;
    end else begin
      case (opcode_s)
        OPC_RTYPE: begin
          case (funct_s)
            FN_ADDU: begin
              reg_write_s = 1'b1;
              reg_dst_s   = 2'd1;
              alu_op_s    = 3'd0;
            end
            FN_SUBU: begin
              reg_write_s = 1'b1;
              reg_dst_s   = 2'd1;
              alu_op_s    = 3'd1;
            end
            FN_JR:   jump_reg_s  = 1'b1;
            FN_SLL:  supported_s = 1'b1;
            default: supported_s = 1'b0;
          endcase
        end
        OPC_ORI: begin
          reg_write_s = 1'b1;
          alu_src_s   = 1'b1;
          alu_op_s    = 3'd2;
          ext_op_s    = 1'b0;
        end
        OPC_LUI: begin
          reg_write_s = 1'b1;
          alu_src_s   = 1'b1;
          alu_op_s    = 3'd3;
        end
        OPC_LW: begin
          reg_write_s  = 1'b1;
          alu_src_s    = 1'b1;
          ext_op_s     = 1'b1;
          mem_to_reg_s = 2'd1;
        end
        OPC_SW: begin
          alu_src_s   = 1'b1;
          ext_op_s    = 1'b1;
          mem_write_s = 1'b1;
        end
        OPC_BEQ: begin
          branch_s = 1'b1;
          alu_op_s = 3'd1;
        end
        OPC_J:   jump_s = 1'b1;
        OPC_JAL: begin
          jump_s       = 1'b1;
          reg_write_s  = 1'b1;
          reg_dst_s    = 2'd2;
          mem_to_reg_s = 2'd2;
        end
        default: supported_s = 1'b0;
      endcase
    end
  end

  // Sticky illegal-encoding flag; reset takes priority over a concurrent bad instr.
  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_r <= 1'b0;
    end else if (!supported_s) begin
      illegal_r <= 1'b1;
    end else begin
      illegal_r <= illegal_r;
    end
  end

  assign RegWrite = reg_write_s;
  assign RegDst   = reg_dst_s;
  assign ALUSrc   = alu_src_s;
  assign ALUOp    = alu_op_s;
  assign ExtOp    = ext_op_s;
  assign MemWrite = mem_write_s;
  assign MemtoReg = mem_to_reg_s;
  assign Branch   = branch_s;
  assign Jump     = jump_s;
  assign JumpReg  = jump_reg_s;
  assign lwso     = lwso_s;
  assign illegal  = illegal_r;

endmodule

// File: tb/tb_decode.sv
// Scoreboard bench for decode: driver pushes hand-computed expectations,
// a negedge monitor pops and compares against the DUT outputs.
module tb_decode;

  logic        clk;
  logic        reset;
  logic [31:0] instr;
  logic        RegWrite;
  logic [1:0]  RegDst;
  logic        ALUSrc;
  logic [2:0]  ALUOp;
  logic        ExtOp;
  logic        MemWrite;
  logic [1:0]  MemtoReg;
  logic        Branch;
  logic        Jump;
  logic        JumpReg;
  logic        lwso;
  logic        illegal;

  int total;
  int bad;

  typedef struct {
    string       name;
    logic [15:0] exp;
  } item_t;

  item_t sbq[$];

  decode dut (
    .clk      (clk),
    .reset    (reset),
    .instr    (instr),
    .RegWrite (RegWrite),
    .RegDst   (RegDst),
    .ALUSrc   (ALUSrc),
    .ALUOp    (ALUOp),
    .ExtOp    (ExtOp),
    .MemWrite (MemWrite),
    .MemtoReg (MemtoReg),
    .Branch   (Branch),
    .Jump     (Jump),
    .JumpReg  (JumpReg),
    .lwso     (lwso),
    .illegal  (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packing order: RegWrite RegDst ALUSrc ALUOp ExtOp MemWrite MemtoReg Branch Jump JumpReg lwso illegal
  function automatic logic [15:0] mk(input logic rw, input logic [1:0] rd, input logic as,
                                     input logic [2:0] op, input logic ext, input logic mw,
                                     input logic [1:0] m2r, input logic br, input logic j,
                                     input logic jr, input logic lw, input logic ill);
    return {rw, rd, as, op, ext, mw, m2r, br, j, jr, lw, ill};
  endfunction

  task automatic issue(input string name, input logic [31:0] ins, input logic rst,
                       input logic [15:0] exp);
    item_t it;
    @(posedge clk);
    #1;
    reset = rst;
    instr = ins;
    it.name = name;
    it.exp  = exp;
    sbq.push_back(it);
  endtask

  // Monitor: outputs are combinational, so compare mid-cycle whenever an item is pending.
  always @(negedge clk) begin
    item_t it;
    logic [15:0] act;
    if (sbq.size() > 0) begin
      it  = sbq.pop_front();
      act = {RegWrite, RegDst, ALUSrc, ALUOp, ExtOp, MemWrite, MemtoReg,
             Branch, Jump, JumpReg, lwso, illegal};
      total++;
      if (act !== it.exp) begin
        bad++;
        $display("FAIL %s: got %b expected %b (instr=%h)", it.name, act, it.exp, instr);
      end
    end
  end

  initial begin
    int waited;
    total = 0;
    bad   = 0;
    reset = 1'b1;
    instr = 32'h0000_0000;

    issue("reset",  32'h0000_0000, 1'b1, mk(1'b0,2'd0,1'b0,3'd0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0));
    issue("sw",     32'hAD09_0004, 1'b0, mk(1'b0,2'd0,1'b1,3'd0,1'b1,1'b1,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0));
    issue("lw",     32'h8D09_0004, 1'b0, mk(1'b1,2'd0,1'b1,3'd0,1'b1,1'b0,2'd1,1'b0,1'b0,1'b0,1'b0,1'b0));
    issue("lwso",   32'hFD09_0004, 1'b0, mk(1'b1,2'd0,1'b1,3'd0,1'b1,1'b0,2'd1,1'b0,1'b0,1'b0,1'b1,1'b0));
    issue("addu",   32'h0022_1821, 1'b0, mk(1'b1,2'd1,1'b0,3'd0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0));
    issue("subu",   32'h0022_1823, 1'b0, mk(1'b1,2'd1,1'b0,3'd1,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0));
    issue("ori",    32'h3421_FFFF, 1'b0, mk(1'b1,2'd0,1'b1,3'd2,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0));
    issue("lui",    32'h3C01_1234, 1'b0, mk(1'b1,2'd0,1'b1,3'd3,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0));
    issue("beq",    32'h1022_0003, 1'b0, mk(1'b0,2'd0,1'b0,3'd1,1'b0,1'b0,2'd0,1'b1,1'b0,1'b0,1'b0,1'b0));
    issue("j",      32'h0800_0010, 1'b0, mk(1'b0,2'd0,1'b0,3'd0,1'b0,1'b0,2'd0,1'b0,1'b1,1'b0,1'b0,1'b0));
    issue("jal",    32'h0C00_0010, 1'b0, mk(1'b1,2'd2,1'b0,3'd0,1'b0,1'b0,2'd2,1'b0,1'b1,1'b0,1'b0,1'b0));
    issue("jr",     32'h03E0_0008, 1'b0, mk(1'b0,2'd0,1'b0,3'd0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b1,1'b0,1'b0));
    issue("sll_sh", 32'h0001_1140, 1'b0, mk(1'b0,2'd0,1'b0,3'd0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0));
    issue("nop",    32'h0000_0000, 1'b0, mk(1'b0,2'd0,1'b0,3'd0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0));
    // Unsupported opcode: controls zero now, flag rises at the next edge and sticks.
    issue("bad_op", 32'hF800_0000, 1'b0, mk(1'b0,2'd0,1'b0,3'd0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0));
    issue("ill_addu", 32'h0022_1821, 1'b0, mk(1'b1,2'd1,1'b0,3'd0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b1));
    issue("ill_lw",   32'h8D09_0004, 1'b0, mk(1'b1,2'd0,1'b1,3'd0,1'b1,1'b0,2'd1,1'b0,1'b0,1'b0,1'b0,1'b1));
    issue("bad_fn",   32'h0022_1820, 1'b0, mk(1'b0,2'd0,1'b0,3'd0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b1));
    // Reset and an illegal instr at the same edge: reset must win.
    issue("rst_bad",  32'hF800_0000, 1'b1, mk(1'b0,2'd0,1'b0,3'd0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b1));
    issue("post_rst", 32'h0022_1821, 1'b0, mk(1'b1,2'd1,1'b0,3'd0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0));
    issue("bad_fn1",  32'h0000_0001, 1'b0, mk(1'b0,2'd0,1'b0,3'd0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0));
    issue("after_fn", 32'h0000_0000, 1'b0, mk(1'b0,2'd0,1'b0,3'd0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b1));

    waited = 0;
    while (sbq.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending items expected 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
